// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter: parity modes, FSM state
// encoding and a counter-width helper.
package uart_pkg;

  // Parity mode selector values
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Bits needed for a counter that runs 0..n-1 (never less than one bit)
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART shifter. The head word is read
// combinationally so a pop can load the shift register on the same edge.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // Both qualifiers use pre-edge state: a push into a full FIFO is refused
  // even if a pop happens on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy next-state; pointers wrap naturally (power of 2)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array write port (contents need no reset)
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready input, TX FIFO, and an FSM that
// sends start, data (LSB first), optional parity and 1/2 stop bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // Out-of-range parity/stop settings fall back to none / one stop bit
  localparam int PAR_EFF  = (PARITY == PAR_ODD || PARITY == PAR_EVEN) ? PARITY : PAR_NONE;
  localparam int STOP_EFF = (STOP_BITS == 2) ? 2 : 1;
  localparam int BAUD_W   = cnt_width(CLKS_PER_BIT);
  localparam int BIT_W    = cnt_width(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_EFF - 1);

  logic [2:0]           state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 baud_end;
  logic                 load;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_valid),
    .pop   (fifo_pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign txd      = txd_q;
  assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);
  assign baud_end = (baud_q == BAUD_LAST);

  // Frame sequencer: bit timing, shifting, and FIFO pops at frame start
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    txd_d    = txd_q;
    fifo_pop = 1'b0;
    load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        load   = !fifo_empty;
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            if (PAR_EFF != PAR_NONE) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = ST_STOP;
              stop_d  = 1'b0;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            txd_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
          stop_d  = 1'b0;
          txd_d   = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            // Chain straight into the next frame when a word is waiting
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        txd_d   = 1'b1;
      end
    endcase

    if (load) begin
      fifo_pop = 1'b1;
      shreg_d  = fifo_dout;
      par_d    = (PAR_EFF == PAR_ODD) ? ~(^fifo_dout) : (^fifo_dout);
      txd_d    = 1'b0;
      baud_d   = '0;
      state_d  = ST_START;
    end
  end

  // Sequencer registers; reset aborts any frame and drives the line idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param. Four instances (8N1, 8E1, 8O1, 7N2)
// share clock and reset; a frame-level reference model predicts txd, busy,
// fifo_count and tx_ready every cycle.
module tb_uart_tx_param;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int NI    = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NI-1:0][8:0] tx_data_w;
  logic [NI-1:0]      tx_valid_w;
  logic [NI-1:0]      tx_ready_w;
  logic [NI-1:0]      txd_w;
  logic [NI-1:0]      busy_w;
  logic [NI-1:0][2:0] fifo_count_w;

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
    .clk(clk), .reset(reset), .tx_data(tx_data_w[0][7:0]), .tx_valid(tx_valid_w[0]),
    .tx_ready(tx_ready_w[0]), .txd(txd_w[0]), .busy(busy_w[0]), .fifo_count(fifo_count_w[0]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8e1 (
    .clk(clk), .reset(reset), .tx_data(tx_data_w[1][7:0]), .tx_valid(tx_valid_w[1]),
    .tx_ready(tx_ready_w[1]), .txd(txd_w[1]), .busy(busy_w[1]), .fifo_count(fifo_count_w[1]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8o1 (
    .clk(clk), .reset(reset), .tx_data(tx_data_w[2][7:0]), .tx_valid(tx_valid_w[2]),
    .tx_ready(tx_ready_w[2]), .txd(txd_w[2]), .busy(busy_w[2]), .fifo_count(fifo_count_w[2]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_7n2 (
    .clk(clk), .reset(reset), .tx_data(tx_data_w[3][6:0]), .tx_valid(tx_valid_w[3]),
    .tx_ready(tx_ready_w[3]), .txd(txd_w[3]), .busy(busy_w[3]), .fifo_count(fifo_count_w[3]));

  // Reference model state: queued words, current frame word, cycles left
  logic [8:0] q_m [NI][8];
  int         qh_m [NI];
  int         qn_m [NI];
  int         rem_m [NI];
  logic [8:0] cur_m [NI];

  // Stimulus: per-instance list of words still to be offered
  logic [8:0] pend [NI][64];
  int         pend_rd [NI];
  int         pend_wr [NI];
  bit         rand_mode;

  int n_checks;
  int n_pass;

  function automatic int db_of(input int k);
    return (k == 3) ? 7 : 8;
  endfunction

  function automatic int par_of(input int k);
    return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
  endfunction

  function automatic int sb_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int flen(input int k);
    return (1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + sb_of(k)) * CPB;
  endfunction

  // Line level expected at cycle idx of a frame carrying word w
  function automatic logic bit_at(input int k, input logic [8:0] w, input int idx);
    int   b;
    logic p;
    b = idx / CPB;
    if (b == 0) return 1'b0;
    if (b <= db_of(k)) return w[b-1];
    if (par_of(k) != 0 && b == db_of(k) + 1) begin
      p = 1'b0;
      for (int i = 0; i < db_of(k); i++) p = p ^ w[i];
      return (par_of(k) == 1) ? ~p : p;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s inst%0d t=%0t: observed %0h expected %0h", tag, k, $time, obs, exp);
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NI; k++) begin
      if (pend_rd[k] != pend_wr[k] && (!rand_mode || $urandom_range(0, 1) == 1)) begin
        tx_valid_w[k] = 1'b1;
        tx_data_w[k]  = pend[k][pend_rd[k] % 64];
      end else begin
        tx_valid_w[k] = 1'b0;
        tx_data_w[k]  = 9'($urandom);
      end
    end
  endtask

  task automatic enqueue(input int k, input logic [8:0] w);
    pend[k][pend_wr[k] % 64] = w;
    pend_wr[k]++;
    drive_inputs();
  endtask

  // One clock: advance the model across the edge, then compare all outputs
  task automatic tick();
    logic [NI-1:0] acc;
    logic [NI-1:0] pop;
    logic          exp_txd;
    for (int k = 0; k < NI; k++) begin
      acc[k] = tx_valid_w[k] && (qn_m[k] < DEPTH) && !reset;
      pop[k] = (rem_m[k] <= 1) && (qn_m[k] != 0) && !reset;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      if (reset) begin
        qh_m[k]  = 0;
        qn_m[k]  = 0;
        rem_m[k] = 0;
      end else begin
        if (rem_m[k] > 0) rem_m[k]--;
        if (pop[k]) begin
          cur_m[k] = q_m[k][qh_m[k]];
          qh_m[k]  = (qh_m[k] + 1) % 8;
          qn_m[k]--;
          rem_m[k] = flen(k);
        end
        if (acc[k]) begin
          q_m[k][(qh_m[k] + qn_m[k]) % 8] = tx_data_w[k];
          qn_m[k]++;
          pend_rd[k]++;
        end
      end
    end
    drive_inputs();
    for (int k = 0; k < NI; k++) begin
      exp_txd = (rem_m[k] > 0) ? bit_at(k, cur_m[k], flen(k) - rem_m[k]) : 1'b1;
      chk("txd", k, 32'(txd_w[k]), 32'(exp_txd));
      chk("busy", k, 32'(busy_w[k]), 32'((rem_m[k] > 0) || (qn_m[k] > 0)));
      chk("fifo_count", k, 32'(fifo_count_w[k]), 32'(qn_m[k]));
      chk("tx_ready", k, 32'(tx_ready_w[k]), 32'(qn_m[k] < DEPTH));
    end
  endtask

  function automatic bit nothing_pending();
    for (int k = 0; k < NI; k++) if (pend_rd[k] != pend_wr[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy_w != '0 || !nothing_pending()) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 0, 32'(busy_w), 32'(0));
    tick();
  endtask

  initial begin
    int n;
    n_checks  = 0;
    n_pass    = 0;
    rand_mode = 1'b0;
    for (int k = 0; k < NI; k++) begin
      pend_rd[k] = 0;
      pend_wr[k] = 0;
      qh_m[k]    = 0;
      qn_m[k]    = 0;
      rem_m[k]   = 0;
      cur_m[k]   = '0;
    end
    drive_inputs();

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      chk("reset_txd", k, 32'(txd_w[k]), 32'(1));
      chk("reset_ready", k, 32'(tx_ready_w[k]), 32'(1));
      chk("reset_busy", k, 32'(busy_w[k]), 32'(0));
      chk("reset_count", k, 32'(fifo_count_w[k]), 32'(0));
    end
    reset = 1'b0;
    tick();

    // 0x41 on 8N1/8E1/8O1; 0x55 then 0x2A back to back on 7N2
    enqueue(0, 9'h41);
    enqueue(1, 9'h41);
    enqueue(2, 9'h41);
    enqueue(3, 9'h55);
    enqueue(3, 9'h2A);
    tick();
    chk("line_idle_at_accept", 0, 32'(txd_w[0]), 32'(1));
    tick();
    chk("start_one_cycle_after_accept", 0, 32'(txd_w[0]), 32'(0));
    wait_idle(400);

    // Six words offered continuously into a depth-4 FIFO
    for (int w = 1; w <= 6; w++) enqueue(0, 9'(w));
    repeat (5) tick();
    chk("full_ready_low", 0, 32'(tx_ready_w[0]), 32'(0));
    chk("full_count", 0, 32'(fifo_count_w[0]), 32'(4));
    wait_idle(600);

    // Word offered only on the last stop cycle with the FIFO empty
    enqueue(0, 9'h5A);
    n = 0;
    while (rem_m[0] != 1 && n < 200) begin
      tick();
      n++;
    end
    chk("last_stop_line", 0, 32'(txd_w[0]), 32'(1));
    enqueue(0, 9'hC3);
    tick();
    chk("idle_reentry_txd", 0, 32'(txd_w[0]), 32'(1));
    chk("idle_reentry_busy", 0, 32'(busy_w[0]), 32'(1));
    tick();
    chk("restart_start_bit", 0, 32'(txd_w[0]), 32'(0));
    wait_idle(200);

    // Reset in the middle of the data bits with two words queued
    enqueue(0, 9'h3C);
    enqueue(0, 9'h11);
    enqueue(0, 9'h22);
    n = 0;
    while (!(rem_m[0] > 0 && flen(0) - rem_m[0] == 3 * CPB + 1) && n < 100) begin
      tick();
      n++;
    end
    chk("mid_data_line", 0, 32'(txd_w[0]), 32'(bit_at(0, 9'h3C, 3 * CPB + 1)));
    chk("mid_data_queued", 0, 32'(fifo_count_w[0]), 32'(2));
    for (int k = 0; k < NI; k++) pend_rd[k] = pend_wr[k];
    drive_inputs();
    reset = 1'b1;
    tick();
    chk("abort_txd", 0, 32'(txd_w[0]), 32'(1));
    chk("abort_count", 0, 32'(fifo_count_w[0]), 32'(0));
    chk("abort_busy", 0, 32'(busy_w[0]), 32'(0));
    chk("abort_ready", 0, 32'(tx_ready_w[0]), 32'(1));
    reset = 1'b0;
    repeat (60) tick();
    chk("no_frames_after_abort", 0, 32'(busy_w[0]), 32'(0));

    // Random words and random valid gaps on all instances
    rand_mode = 1'b1;
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 3) == 0) enqueue(int'($urandom_range(0, NI - 1)), 9'($urandom));
      tick();
    end
    rand_mode = 1'b0;
    drive_inputs();
    wait_idle(4000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter with a valid/ready input interface and a small TX FIFO. It serialises words LSB-first as start, DATA_BITS data bits, optional parity, then 1 or 2 stop bits. It sits between the board-level command logic and the FPGA TX pin. Back-to-back frames go out with no idle gap while the FIFO is non-empty.

Parameters:
CLKS_PER_BIT, 10417, clk cycles per bit (100 MHz / 9600 baud); legal range >= 2
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, >= 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
tx_data  in  DATA_BITS  word to send; sampled only on accept
tx_valid  in  1  tx_data is valid
tx_ready  out  1  FIFO can accept; equals !full
txd  out  1  serial line, idle high, registered
busy  out  1  high while a frame is in progress or the FIFO is non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset is synchronous and active-high on clk. Reset values: txd=1, tx_ready=1, busy=0, fifo_count=0, FSM=IDLE, baud counter=0.
- Reset mid-frame aborts the frame and flushes the FIFO. txd returns high on the reset edge.
- Accept rule: an accept happens on an edge where tx_valid && tx_ready. tx_ready is !full, evaluated before any same-cycle pop.
- A push into a full FIFO is refused even if a pop happens on the same edge.
- On an empty FIFO, a push and a pop on the same edge cannot collide, because a pop requires the FIFO to be non-empty before the edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if the FIFO is non-empty, pop the head into the shift register, compute parity, and go to START. txd<=0 on the same edge.
- Latency: a word accepted at edge E into an empty FIFO while in IDLE pops at E+1. txd goes low at E+1.
- Each bit is held exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1, is cleared on entry to START, and is frozen at 0 in IDLE.
- DATA: shift right once per bit, with txd = shreg[0]. After DATA_BITS bits, go to PARITY if PARITY != 0, otherwise to STOP.
- PARITY: even parity = XOR of the data bits; odd parity = its inverse.
- STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of the last stop cycle: if the FIFO is non-empty, pop and go directly to START (no idle cycle). Otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- busy = (state != IDLE) || (fifo_count != 0).
- Illegal PARITY values are treated as none. Illegal STOP_BITS values are treated as 1.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count saturates at neither bound; legal handshake makes overflow and underflow impossible.

Decomposition:
- Shared package uart_pkg holds:
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN
  - FSM state encoding localparams
  - a width helper for counter sizing
- One sub-module: uart_tx_fifo, a synchronous FIFO parametrised on WIDTH/DEPTH, with push, pop, dout, full, empty and count ports.
- The FSM, baud counter and shift register live in the top module.

Test Plan:
- CLKS_PER_BIT=4, 8N1, send 0x41 -> txd bits 0,1,0,0,0,0,0,1,0,1, each for 4 cycles; 40 cycles total; txd low exactly 1 cycle after accept.
- PARITY=2, send 0x41 -> parity bit 0; PARITY=1 -> parity bit 1; frame 44 cycles.
- DATA_BITS=7, STOP_BITS=2, send 0x55 -> bits 0,1,0,1,0,1,0,1,1,1; frame 40 cycles; no gap before the next frame's start bit.
- FIFO_DEPTH=4, tx_valid held for 6 words 0x01..0x06 -> first 5 accepted, tx_ready low until the 2nd frame pops; all 6 frames contiguous; busy falls after the final stop bit.
- Assert reset mid-DATA of 0x3C with 2 words queued -> next edge: txd=1, fifo_count=0, busy=0, tx_ready=1; no further frames sent.
- tx_valid pulse on the last stop cycle of a frame, FIFO empty -> new start bit begins exactly 1 cycle after IDLE is re-entered.
